// File: rtl/mips_div_pkg.sv
// mips_div_pkg
//   Shared definitions for the MIPS div/divu unit.
//   - div_state_t : FSM states (IDLE, RUN, FIX)
//   - DIV_WIDTH   : default operand/result width
//   - DIV_CNT_W   : width of a step counter that can hold DIV_WIDTH
package mips_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/div_step.sv
// div_step
//   One combinational restoring-division step on unsigned magnitudes.
//   Ports:
//     rem      in  WIDTH  partial remainder (always < divisor)
//     quo      in  WIDTH  quotient/dividend shift register
//     divisor  in  WIDTH  divisor magnitude (non-zero)
//     rem_next out WIDTH  partial remainder after the step
//     quo_next out WIDTH  shift register after the step (new quotient bit in LSB)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // {rem, quo} shifted left by one: the remainder gains the dividend MSB.
  // Since rem < divisor, the shifted value fits in WIDTH+1 bits and the
  // trial difference lies in [-divisor, divisor-1], so its MSB is the sign.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit
//   Multi-cycle restoring divider for MIPS div/divu writing the HI/LO pair.
//   Latency WIDTH+1 edges from the start edge to the done pulse (1 edge for
//   a zero divisor). Back-to-back starts are accepted in the done cycle.
//   Ports:
//     clk          in  1      system clock
//     rst_n        in  1      asynchronous active-low reset
//     start        in  1      request, sampled only in IDLE
//     is_signed    in  1      1 = div, 0 = divu
//     dividend     in  WIDTH  rs value
//     divisor      in  WIDTH  rt value
//     busy         out 1      operation in flight
//     done         out 1      one-cycle pulse, results updated
//     quotient     out WIDTH  LO
//     remainder    out WIDTH  HI
//     div_by_zero  out 1      last completed operation had a zero divisor
module mips_div_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             zero_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_by_zero_reg;

  // Operand conditioning: magnitudes and sign flags taken from the inputs.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so MIN / -1 needs no special handling.
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvs_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rem_reg         <= '0;
      quo_reg         <= '0;
      dvs_reg         <= '0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      zero_reg        <= 1'b0;
      done_reg        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            dvs_reg   <= b_mag;
            quo_reg   <= a_mag;
            if (divisor == '0) begin
              // Park the raw dividend in rem_reg: it is the HI result.
              zero_reg  <= 1'b1;
              rem_reg   <= dividend;
              cnt_reg   <= '0;
              state_reg <= FIX;
            end else begin
              zero_reg  <= 1'b0;
              rem_reg   <= '0;
              cnt_reg   <= CW'(WIDTH);
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          rem_reg <= step_rem;
          quo_reg <= step_quo;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          if (zero_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= rem_reg;
          end else begin
            quotient_reg  <= neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
            remainder_reg <= neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
          end
          div_by_zero_reg <= zero_reg;
          done_reg        <= 1'b1;
          state_reg       <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule
